// File: rtl/axi_llc_pkg.sv
// axi_llc_pkg: shared constants and route FSM states for the LLC miss router
package axi_llc_pkg;
   localparam int unsigned UseIdBits        = 2;
   localparam int unsigned MissCntWidth     = 4;
   localparam int unsigned MissCntMaxWWidth = 5;
   typedef enum logic [1:0] {IDLE, HOLD_HIT, HOLD_MISS, FLUSH} route_state_e;
endpackage

// File: rtl/axi_llc_miss_route_cnt.sv
// axi_llc_miss_route_cnt: per-ID and write-order outstanding-miss counters
module axi_llc_miss_route_cnt
   import axi_llc_pkg::*;
#(
   parameter int unsigned IdxWidth  = UseIdBits,
   parameter int unsigned CntWidth  = MissCntWidth,
   parameter int unsigned WCntWidth = MissCntMaxWWidth,
   localparam int unsigned NoCnt    = 2**IdxWidth
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           up_valid_i,
   input  logic [IdxWidth-1:0]            up_idx_i,
   input  logic                           up_rw_i,
   input  logic                           dn_valid_i,
   input  logic [IdxWidth-1:0]            dn_idx_i,
   input  logic                           dn_rw_i,
   output logic [NoCnt-1:0][CntWidth-1:0] cnt_o,
   output logic [WCntWidth-1:0]           wcnt_o,
   output logic                           all_zero_o,
   output logic [NoCnt-1:0]               cnt_max_o,
   output logic                           wcnt_max_o
);
   logic [CntWidth-1:0]  r_cnt [NoCnt];
   logic [WCntWidth-1:0] r_wcnt;
   logic                 w_wup, w_wdn;
   for (genvar g = 0; g < NoCnt; g++) begin : g_cnt
      logic w_up, w_dn;
      assign w_up = up_valid_i && (up_idx_i == IdxWidth'(g));
      assign w_dn = dn_valid_i && (dn_idx_i == IdxWidth'(g));
      // simultaneous up and down cancel; a down at zero is absorbed
      always_ff @(posedge clk_i) begin
         if (!rst_ni) r_cnt[g] <= '0;
         else if (w_up && !w_dn) r_cnt[g] <= r_cnt[g] + 1'b1;
         else if (w_dn && !w_up && r_cnt[g] != '0) r_cnt[g] <= r_cnt[g] - 1'b1;
         if (rst_ni) assert (!(w_dn && !w_up && r_cnt[g] == '0));
      end
      assign cnt_o[g]     = r_cnt[g];
      assign cnt_max_o[g] = &r_cnt[g];
   end
   assign w_wup = up_valid_i && up_rw_i;
   assign w_wdn = dn_valid_i && dn_rw_i;
   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_wcnt <= '0;
      else if (w_wup && !w_wdn) r_wcnt <= r_wcnt + 1'b1;
      else if (w_wdn && !w_wup && r_wcnt != '0) r_wcnt <= r_wcnt - 1'b1;
      if (rst_ni) assert (!(w_wdn && !w_wup && r_wcnt == '0));
   end
   assign wcnt_o     = r_wcnt;
   assign wcnt_max_o = &r_wcnt;
   assign all_zero_o = ~|{cnt_o, wcnt_o};
endmodule

// File: rtl/axi_llc_miss_route_ctrl.sv
// axi_llc_miss_route_ctrl: steers looked-up LLC descriptors to hit or miss pipeline, with ordering stalls and flush drain.
// Optional AXI_LLC_MISS_ROUTE_PERF_EN adds saturating hit/miss/stall performance counters.
module axi_llc_miss_route_ctrl
   import axi_llc_pkg::*;
#(
   parameter int unsigned IdWidth          = 4,
   parameter int unsigned UseIdBits        = axi_llc_pkg::UseIdBits,
   parameter int unsigned MissCntWidth     = axi_llc_pkg::MissCntWidth,
   parameter int unsigned MissCntMaxWWidth = axi_llc_pkg::MissCntMaxWWidth
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               desc_valid_i,
   output logic               desc_ready_o,
   input  logic [IdWidth-1:0] desc_id_i,
   input  logic               desc_rw_i,
   input  logic               desc_hit_i,
   output logic               hit_valid_o,
   input  logic               hit_ready_i,
   output logic               miss_valid_o,
   input  logic               miss_ready_i,
   output logic [IdWidth-1:0] out_id_o,
   output logic               out_rw_o,
   input  logic               miss_done_i,
   input  logic [IdWidth-1:0] miss_done_id_i,
   input  logic               miss_done_rw_i,
   input  logic               flush_req_i,
   output logic               flush_ack_o,
`ifdef AXI_LLC_MISS_ROUTE_PERF_EN
   output logic [31:0]        perf_hit_o,
   output logic [31:0]        perf_miss_o,
   output logic [31:0]        perf_stall_o,
   output logic               idle_o
`else
   output logic               idle_o
`endif
);
   localparam int unsigned NoCounters = 2**UseIdBits;
   route_state_e                             r_state;
   logic                                     r_hit_valid, r_miss_valid, r_out_rw, r_flush_ack;
   logic [IdWidth-1:0]                       r_out_id;
   logic [UseIdBits-1:0]                     w_idx;
   logic [NoCounters-1:0][MissCntWidth-1:0]  w_cnt;
   logic [MissCntMaxWWidth-1:0]              w_wcnt;
   logic [NoCounters-1:0]                    w_cnt_max;
   logic                                     w_wcnt_max, w_all_zero, w_to_miss, w_stall, w_accept;
   logic                                     w_done_id_unused;
   assign w_idx            = desc_id_i[UseIdBits-1:0];
   assign w_done_id_unused = ^miss_done_id_i[IdWidth-1:UseIdBits];
   // a hit must still queue behind older misses of its ID, and writes behind any write miss
   assign w_to_miss    = ~desc_hit_i | (w_cnt[w_idx] != '0) | (desc_rw_i & (w_wcnt != '0));
   assign w_stall      = w_to_miss & (w_cnt_max[w_idx] | (desc_rw_i & w_wcnt_max));
   assign desc_ready_o = (r_state == IDLE) & ~w_stall & ~flush_req_i;
   assign w_accept     = desc_valid_i & desc_ready_o;
   axi_llc_miss_route_cnt #(
      .IdxWidth  (UseIdBits),
      .CntWidth  (MissCntWidth),
      .WCntWidth (MissCntMaxWWidth)
   ) u_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .up_valid_i (w_accept & w_to_miss),
      .up_idx_i   (w_idx),
      .up_rw_i    (desc_rw_i),
      .dn_valid_i (miss_done_i),
      .dn_idx_i   (miss_done_id_i[UseIdBits-1:0]),
      .dn_rw_i    (miss_done_rw_i),
      .cnt_o      (w_cnt),
      .wcnt_o     (w_wcnt),
      .all_zero_o (w_all_zero),
      .cnt_max_o  (w_cnt_max),
      .wcnt_max_o (w_wcnt_max)
   );
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state      <= IDLE;
         r_hit_valid  <= 1'b0;
         r_miss_valid <= 1'b0;
         r_out_id     <= '0;
         r_out_rw     <= 1'b0;
         r_flush_ack  <= 1'b0;
      end else begin
         r_flush_ack <= 1'b0;
         case (r_state)
            IDLE:
               if (flush_req_i) r_state <= FLUSH;
               else if (w_accept) begin
                  r_out_id     <= desc_id_i;
                  r_out_rw     <= desc_rw_i;
                  r_hit_valid  <= ~w_to_miss;
                  r_miss_valid <= w_to_miss;
                  r_state      <= w_to_miss ? HOLD_MISS : HOLD_HIT;
               end
            HOLD_HIT:
               if (hit_ready_i) begin
                  r_hit_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            HOLD_MISS:
               if (miss_ready_i) begin
                  r_miss_valid <= 1'b0;
                  r_state      <= IDLE;
               end
            FLUSH:
               if (w_all_zero) begin
                  r_flush_ack <= 1'b1;
                  r_state     <= IDLE;
               end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign hit_valid_o  = r_hit_valid;
   assign miss_valid_o = r_miss_valid;
   assign out_id_o     = r_out_id;
   assign out_rw_o     = r_out_rw;
   assign flush_ack_o  = r_flush_ack;
   assign idle_o       = w_all_zero & (r_state inside {IDLE, FLUSH});
`ifdef AXI_LLC_MISS_ROUTE_PERF_EN
   logic [31:0] r_perf_hit, r_perf_miss, r_perf_stall;
   logic        w_stall_cycle;
   assign w_stall_cycle = (r_state == IDLE) & desc_valid_i & ~desc_ready_o;
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_perf_hit   <= '0;
         r_perf_miss  <= '0;
         r_perf_stall <= '0;
      end else begin
         if (w_accept & ~w_to_miss & ~&r_perf_hit) r_perf_hit <= r_perf_hit + 1'b1;
         if (w_accept & w_to_miss & ~&r_perf_miss) r_perf_miss <= r_perf_miss + 1'b1;
         if (w_stall_cycle & ~&r_perf_stall) r_perf_stall <= r_perf_stall + 1'b1;
      end
   end
   assign perf_hit_o   = r_perf_hit;
   assign perf_miss_o  = r_perf_miss;
   assign perf_stall_o = r_perf_stall;
`endif
endmodule

// File: tb/tb_axi_llc_miss_route_ctrl.sv
// tb_axi_llc_miss_route_ctrl: directed scoreboard bench for the LLC miss router
module tb_axi_llc_miss_route_ctrl;
   logic       clk_i = 1'b0, rst_ni = 1'b0;
   logic       desc_valid_i = 1'b0, desc_rw_i = 1'b0, desc_hit_i = 1'b0;
   logic [3:0] desc_id_i = '0;
   logic       desc_ready_o, hit_valid_o, miss_valid_o, out_rw_o, flush_ack_o, idle_o;
   logic       hit_ready_i = 1'b1, miss_ready_i = 1'b1;
   logic [3:0] out_id_o;
   logic       miss_done_i = 1'b0, miss_done_rw_i = 1'b0, flush_req_i = 1'b0;
   logic [3:0] miss_done_id_i = '0;
   typedef struct {logic miss; logic [3:0] id; logic rw;} exp_t;
   exp_t sb[$];
   int   total = 0, passed = 0, ack_cnt = 0;
   int   mcnt[4] = '{0, 0, 0, 0};
   int   mwcnt = 0;

   axi_llc_miss_route_ctrl dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o), .desc_id_i(desc_id_i),
      .desc_rw_i(desc_rw_i), .desc_hit_i(desc_hit_i),
      .hit_valid_o(hit_valid_o), .hit_ready_i(hit_ready_i),
      .miss_valid_o(miss_valid_o), .miss_ready_i(miss_ready_i),
      .out_id_o(out_id_o), .out_rw_o(out_rw_o),
      .miss_done_i(miss_done_i), .miss_done_id_i(miss_done_id_i), .miss_done_rw_i(miss_done_rw_i),
      .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o), .idle_o(idle_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_cnts(input string tag);
      for (int i = 0; i < 4; i++) chk($sformatf("%s cnt[%0d]", tag, i), 32'(dut.w_cnt[i]), mcnt[i]);
      chk({tag, " wcnt"}, 32'(dut.w_wcnt), mwcnt);
   endtask

   task automatic send(input logic [3:0] id, input logic rw, input logic hit, input logic miss);
      int   n = 0;
      exp_t e;
      desc_valid_i = 1'b1; desc_id_i = id; desc_rw_i = rw; desc_hit_i = hit;
      #1;
      while (!desc_ready_o && n < 40) begin
         @(negedge clk_i); #1; n++;
      end
      chk("accept ready", desc_ready_o, 1);
      e.miss = miss; e.id = id; e.rw = rw;
      sb.push_back(e);
      if (miss) begin
         mcnt[id[1:0]]++;
         if (rw) mwcnt++;
      end
      @(posedge clk_i); #1;
      desc_valid_i = 1'b0;
      chk(miss ? "miss_valid" : "hit_valid", miss ? miss_valid_o : hit_valid_o, 1);
      @(negedge clk_i);
   endtask

   task automatic done(input logic [3:0] id, input logic rw);
      miss_done_i = 1'b1; miss_done_id_i = id; miss_done_rw_i = rw;
      @(negedge clk_i);
      miss_done_i = 1'b0;
      mcnt[id[1:0]]--;
      if (rw) mwcnt--;
   endtask

   // consumer side of the scoreboard: sampled just before the handshake edge
   always @(negedge clk_i) begin
      #4;
      if (flush_ack_o) ack_cnt++;
      if ((hit_valid_o && hit_ready_i) || (miss_valid_o && miss_ready_i)) begin
         chk("sb has entry", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb route", miss_valid_o, e.miss);
            chk("sb out_id", out_id_o, e.id);
            chk("sb out_rw", out_rw_o, e.rw);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      repeat (2) @(negedge clk_i);
      chk("rst idle", idle_o, 1);
      chk("rst hit_valid", hit_valid_o, 0);
      chk("rst miss_valid", miss_valid_o, 0);
      chk("rst flush_ack", flush_ack_o, 0);
      chk("rst out_id", out_id_o, 0);
      chk_cnts("rst");
      rst_ni = 1'b1;
      @(negedge clk_i);
      send(4'd1, 1'b0, 1'b1, 1'b0);
      chk("t1 out_id", out_id_o, 1);
      chk_cnts("t1");
      send(4'd2, 1'b1, 1'b0, 1'b1);
      chk_cnts("t2 wmiss");
      send(4'd2, 1'b0, 1'b1, 1'b1);
      chk_cnts("t2 order");
      send(4'd3, 1'b0, 1'b1, 1'b0);
      done(4'd2, 1'b1);
      done(4'd2, 1'b0);
      chk_cnts("t2 drain");
      for (int i = 0; i < 15; i++) send(4'd0, 1'b0, 1'b0, 1'b1);
      chk_cnts("t3 full");
      desc_valid_i = 1'b1; desc_id_i = 4'd0; desc_rw_i = 1'b0; desc_hit_i = 1'b0;
      @(negedge clk_i); #1;
      chk("t3 stall ready", desc_ready_o, 0);
      @(negedge clk_i);
      miss_done_i = 1'b1; miss_done_id_i = 4'd0; miss_done_rw_i = 1'b0;
      #1;
      chk("t3 stall during done", desc_ready_o, 0);
      @(negedge clk_i);
      miss_done_i = 1'b0;
      mcnt[0]--;
      chk_cnts("t3 released");
      send(4'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 15; i++) done(4'd0, 1'b0);
      chk_cnts("t3 drain");
      repeat (3) send(4'd1, 1'b0, 1'b0, 1'b1);
      chk_cnts("t4 pre");
      @(negedge clk_i);
      desc_valid_i = 1'b1; desc_id_i = 4'd1; desc_rw_i = 1'b0; desc_hit_i = 1'b0;
      miss_done_i = 1'b1; miss_done_id_i = 4'd1; miss_done_rw_i = 1'b0;
      #1;
      chk("t4 ready", desc_ready_o, 1);
      begin
         exp_t e;
         e.miss = 1'b1; e.id = 4'd1; e.rw = 1'b0;
         sb.push_back(e);
      end
      @(posedge clk_i); #1;
      desc_valid_i = 1'b0; miss_done_i = 1'b0;
      chk("t4 miss_valid", miss_valid_o, 1);
      @(negedge clk_i);
      chk_cnts("t4 updown");
      done(4'd1, 1'b0);
      flush_req_i = 1'b1;
      #1;
      chk("t5 flush ready", desc_ready_o, 0);
      @(negedge clk_i); #1;
      flush_req_i = 1'b0;
      #1;
      chk("t5 flush sticky ready", desc_ready_o, 0);
      @(negedge clk_i);
      chk("t5 no early ack", ack_cnt, 0);
      done(4'd1, 1'b0);
      done(4'd1, 1'b0);
      n = 0;
      while (!flush_ack_o && n < 20) begin
         @(negedge clk_i); #1; n++;
      end
      chk("t5 flush ack", flush_ack_o, 1);
      repeat (3) @(negedge clk_i);
      chk("t5 ack pulses", ack_cnt, 1);
      chk("t5 idle", idle_o, 1);
      chk_cnts("t5");
      send(4'd3, 1'b0, 1'b1, 1'b0);
      miss_ready_i = 1'b0;
      send(4'd1, 1'b1, 1'b0, 1'b1);
      chk_cnts("t6 pre");
      @(negedge clk_i);
      chk("t6 miss held", miss_valid_o, 1);
      rst_ni = 1'b0;
      @(negedge clk_i); #1;
      chk("t6 miss_valid", miss_valid_o, 0);
      chk("t6 idle", idle_o, 1);
      void'(sb.pop_front());
      mcnt = '{0, 0, 0, 0};
      mwcnt = 0;
      chk_cnts("t6");
      rst_ni = 1'b1;
      miss_ready_i = 1'b1;
      @(negedge clk_i);
      send(4'd2, 1'b0, 1'b1, 1'b0);
      repeat (2) @(negedge clk_i);
      chk("sb drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/axi_llc_miss_route_ctrl.md
Name: axi_llc_miss_route_ctrl

Overview:
Steers each LLC descriptor, after tag lookup, to either the hit pipeline or the miss pipeline. It keeps per-ID and write-order outstanding-miss counts so that same-ID traffic stays in order and all writes stay in order, and it stalls intake when a count would overflow. It also provides a flush handshake that drains the miss pipeline before configuration changes.

Parameters:
IdWidth, 4, AXI slave ID width of descriptors
UseIdBits, 2, ID LSBs used for counter indexing; NoCounters = 2**UseIdBits
MissCntWidth, 4, width of each per-ID outstanding-miss counter
MissCntMaxWWidth, 5, width of the write outstanding-miss counter

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset; synchronous, active-low
desc_valid_i  in  1  descriptor valid (from tag lookup)
desc_ready_o  out  1  descriptor accepted
desc_id_i  in  IdWidth  descriptor AXI ID
desc_rw_i  in  1  0 = read, 1 = write
desc_hit_i  in  1  tag lookup hit
hit_valid_o  out  1  registered descriptor to hit pipeline
hit_ready_i  in  1  hit pipeline ready
miss_valid_o  out  1  registered descriptor to miss pipeline
miss_ready_i  in  1  miss pipeline ready
out_id_o  out  IdWidth  ID of the held descriptor
out_rw_o  out  1  rw of the held descriptor
miss_done_i  in  1  a descriptor leaves the miss pipeline (single-cycle pulse)
miss_done_id_i  in  IdWidth  its ID
miss_done_rw_i  in  1  its rw
flush_req_i  in  1  level request to drain the miss pipeline
flush_ack_o  out  1  one-cycle pulse: drained
idle_o  out  1  all counters zero and no descriptor held

Behaviour:
- Reset (rst_ni low at a clock edge): FSM goes to IDLE, all counters 0, all valids 0, flush_ack_o 0, out_* 0, idle_o 1. Reset mid-transfer drops the held descriptor.
- Index = desc_id_i[UseIdBits-1:0].
- to_miss = ~desc_hit_i | (cnt[idx] != 0) | (desc_rw_i & (wcnt != 0)).
- stall = to_miss & ((cnt[idx] == max) | (desc_rw_i & wcnt == max)). max is the all-ones value.
- FSM states:
  - IDLE: desc_ready_o = ~stall & ~flush_req_i.
    - On valid & ready: latch id/rw and go to HOLD_MISS if to_miss, else HOLD_HIT.
    - If flush_req_i is high, go to FLUSH; flush has priority over intake.
  - HOLD_HIT: hit_valid_o = 1. On hit_ready_i, go to IDLE.
  - HOLD_MISS: miss_valid_o = 1. On miss_ready_i, go to IDLE.
  - FLUSH: desc_ready_o = 0. When all counters are 0, pulse flush_ack_o for one cycle and go to IDLE. A deasserted flush_req_i is ignored once FLUSH has been entered.
- Valids are never retracted and out_* are held stable while a valid is pending.
- Latency: 1 cycle from acceptance to output valid. Throughput is 1 descriptor per 2 cycles; there is no bypass.
- Count up happens at acceptance on the miss route (cnt[idx]++, plus wcnt++ if rw), not at the miss handshake.
- Count down happens on miss_done_i (cnt[done_idx]--, plus wcnt-- if done_rw).
- Simultaneous up and down on the same counter: net no change.
- Down while a counter is 0: the counter stays 0 and a simulation assertion fires.
- Up never reaches a wrapped value, because stall prevents acceptance at max.
- idle_o is combinational from counters and state.

Optional Feature:
AXI_LLC_MISS_ROUTE_PERF_EN
- Defined: adds outputs perf_hit_o, perf_miss_o and perf_stall_o, each 32 bits, saturating, reset to 0.
  - perf_hit_o / perf_miss_o increment on acceptance to the hit / miss route.
  - perf_stall_o increments each cycle with desc_valid_i & ~desc_ready_o in IDLE.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- axi_llc_pkg: UseIdBits, MissCntWidth, MissCntMaxWWidth constants, and the route_state_e enum {IDLE, HOLD_HIT, HOLD_MISS, FLUSH}.
- Sub-module axi_llc_miss_route_cnt: bank of NoCounters per-ID counters plus the write counter. It has up and down index/rw/valid inputs and exposes count values, an all-zero flag and at-max flags. The FSM and output stage stay in the top module.

Test Plan:
- Hit, ID 1, read, counters 0 -> hit_valid_o = 1 next cycle, out_id_o = 1, all counters stay 0.
- Miss, ID 2, write -> miss_valid_o = 1, cnt[2] = 1, wcnt = 1. A following hit read on ID 2 -> routed to miss, cnt[2] = 2. A hit read on ID 3 -> routed to hit.
- Accept 15 misses on ID 0 with MissCntWidth 4 -> cnt[0] = 15. The next ID-0 miss is held with desc_ready_o = 0. One miss_done_i on ID 0 -> accepted next cycle.
- Up and down on ID 1 in the same cycle with cnt[1] = 3 -> cnt[1] stays 3.
- flush_req_i with 2 outstanding misses -> desc_ready_o = 0. After 2 miss_done_i pulses, flush_ack_o pulses once, then the FSM returns to IDLE.
- rst_ni low while in HOLD_MISS with miss_ready_i = 0 -> next cycle miss_valid_o = 0, all counters 0, idle_o = 1.
